ram16k_bist: RTL and testbench
==============================

# ram16k_bist

Built-in self-test initiator for the 16K x 16 RAM. It drives the RAM's write port (value, load, address) and checks its read output. On `start` it writes a seeded pattern to every address, then reads it back and compares. It repeats the write and compare with the inverted pattern, and reports pass or the first failing address and data. It sits beside `ram16k` and owns that port whenever `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 14, RAM address width.
- `DATA_W`, 16, RAM word width.
- `LAST_ADDR`, 2**ADDR_W-1, highest address tested; benches shrink it for speed.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge.
- `start`  in  1  request a test run; sampled only in IDLE or DONE.
- `seed`  in  DATA_W  pattern seed; captured on the accepted start.
- `busy`  out  1  high from the cycle after start is accepted until DONE is reached.
- `done`  out  1  level; high in DONE until the next accepted start or reset.
- `pass`  out  1  valid while done is high; 1 means no mismatch.
- `fail_addr`  out  ADDR_W  first mismatching address; 0 if pass.
- `fail_data`  out  DATA_W  ram_out value seen at fail_addr; 0 if pass.
- `ram_value`  out  DATA_W  write data to the RAM `value` port.
- `ram_load`  out  1  write enable to the RAM `load` port.
- `ram_address`  out  ADDR_W  to the RAM `address` port.
- `ram_out`  in  DATA_W  from the RAM `out` port.

## Operation
- RAM contract: the write takes effect on the rising edge while `load` is 1. The read is combinational: `out` = mem[address] within the same cycle.
- Pattern: pat(a) = zero-extend(a) XOR seed_q. Phase 1 uses pat(a), phase 2 uses ~pat(a).
- FSM states: IDLE, W0, R0, W1, R1, DONE.
- IDLE/DONE:
  - start=1 captures seed, clears done/pass/fail_*.
  - Next state W0, address counter to 0.
- W0/W1:
  - ram_load=1, ram_address=cnt, ram_value=pattern(cnt); cnt increments each cycle.
  - At cnt==LAST_ADDR, go to R0/R1 with cnt=0.
- R0/R1:
  - ram_load=0, ram_address=cnt.
  - At each edge, compare ram_out with the expected pattern.
  - Mismatch: go to DONE with pass=0, fail_addr=cnt, fail_data=ram_out. The test stops at the first mismatch.
  - Match at cnt==LAST_ADDR: R0 goes to W1; R1 goes to DONE with pass=1.
- Address counter is ADDR_W bits wide and never wraps past LAST_ADDR.
- Every output is registered. ram_value is 0 whenever ram_load is 0.

## Timing
- Reset: state IDLE, cnt=0. Outputs busy, done, pass, ram_load = 0; fail_addr, fail_data, ram_value, ram_address = 0.
- Reset mid-run aborts the run; ram_load is 0 from the cycle following that edge. Reset beats a simultaneous start.
- Start accepted at edge E0 → busy=1 and ram_load=1 with address 0 during cycle E0..E1.
- Run length for N = LAST_ADDR+1 addresses:
  - A clean run spends 4N cycles in W0/R0/W1/R1.
  - done=1 and busy=0 from edge E0+4N.
- A mismatch at read step k of phase p sets done at the edge ending that read cycle.
- start while busy is ignored. start held high in DONE restarts the run immediately.

## Structure
- Shared package `ram16k_bist_pkg` holds:
  - the state enum;
  - ADDR_W/DATA_W defaults;
  - the pattern function pat(a, seed, phase).
- No sub-module in RTL.
- The bench needs one helper, `ram16k_fault`: a wrapper around `ram16k` that can force one data bit of one address stuck at 0 or 1.

## Test plan
- Reset check: assert reset 3 cycles, no start → all outputs 0, state IDLE.
- Clean run: LAST_ADDR=15, seed=16'h0003, start one cycle → ram_load high for 16 cycles on addresses 0..15 with value a^3. done=1, pass=1 exactly 64 cycles after acceptance; busy falls the same edge.
- Phase-0 fault: addr 9 bit 2 stuck-at-1, seed=16'h0000 → done in R0 at read of address 9, pass=0, fail_addr=9, fail_data=16'h000D; W1 never entered.
- Phase-2-only fault: addr 4 bit 15 stuck-at-0, seed=16'h0000 → phase 1 passes; R1 mismatch at addr 4: fail_addr=4, fail_data=16'h7FFB (expected 16'hFFFB).
- Abort and restart: reset during W1 at cnt=7 → next cycle ram_load=0, busy=0. A new start with seed=16'hFFFF then completes with pass=1. start pulses mid-run are ignored.
- Full size: LAST_ADDR=16383 default, seed=16'hA5A5 → pass=1 after 65536 cycles. Then spot-check the last writes: address 4739 holds ~(16'h1283^16'hA5A5) and address 10861 holds ~(16'h2A6D^16'hA5A5).

Source files
------------

// File: rtl/ram16k_bist_pkg.sv
// Shared types and the test pattern for the 16K x 16 RAM self-test.
package ram16k_bist_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0,
        W1,
        R1,
        DONE
    } state_t;

    function automatic logic [DATA_W_DEF-1:0] pat(
        input logic [DATA_W_DEF-1:0] a,
        input logic [DATA_W_DEF-1:0] seed,
        input logic                  phase
    );
        logic [DATA_W_DEF-1:0] p;
        p = a ^ seed;
        return phase ? ~p : p;
    endfunction

endpackage

// File: rtl/ram16k_bist.sv
// March-style write/compare BIST for ram16k: seeded pattern, then its inverse.
// Stops at the first mismatch and holds the failing address and data.
module ram16k_bist
    import ram16k_bist_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LAST_ADDR = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] ram_value,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] seed_q, seed_n;
    logic              pass_n;
    logic [ADDR_W-1:0] fail_addr_n;
    logic [DATA_W-1:0] fail_data_n;
    logic [DATA_W-1:0] expect_w;
    logic              load_n;
    logic [DATA_W-1:0] value_n;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        seed_n      = seed_q;
        pass_n      = pass;
        fail_addr_n = fail_addr;
        fail_data_n = fail_data;
        expect_w    = pat(DATA_W'(cnt), seed_q, state == R1);
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n     = W0;
                    cnt_n       = '0;
                    seed_n      = seed;
                    pass_n      = 1'b0;
                    fail_addr_n = '0;
                    fail_data_n = '0;
                end
            end
            W0, W1: begin
                if (cnt == LAST) begin
                    state_n = (state == W0) ? R0 : R1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            R0, R1: begin
                if (ram_out != expect_w) begin
                    state_n     = DONE;
                    cnt_n       = '0;
                    pass_n      = 1'b0;
                    fail_addr_n = cnt;
                    fail_data_n = ram_out;
                end else if (cnt == LAST) begin
                    cnt_n = '0;
                    if (state == R0) begin
                        state_n = W1;
                    end else begin
                        state_n = DONE;
                        pass_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // RAM drive is derived from the next state so the port is fully registered.
    always_comb begin
        load_n  = (state_n == W0) || (state_n == W1);
        value_n = '0;
        if (load_n)
            value_n = pat(DATA_W'(cnt_n), seed_n, state_n == W1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            seed_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            ram_value   <= '0;
            ram_load    <= 1'b0;
            ram_address <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            seed_q      <= seed_n;
            busy        <= (state_n != IDLE) && (state_n != DONE);
            done        <= (state_n == DONE);
            pass        <= pass_n;
            fail_addr   <= fail_addr_n;
            fail_data   <= fail_data_n;
            ram_value   <= value_n;
            ram_load    <= load_n;
            ram_address <= cnt_n;
        end
    end

endmodule

// File: tb/tb_ram16k_bist.sv
// Directed bench for ram16k_bist against a behavioural RAM with stuck-bit injection.
module ram16k #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (load)
            mem[address] <= value;
    end

    assign out = mem[address];
endmodule

module ram16k_fault #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    input  logic              fault_en,
    input  logic [ADDR_W-1:0] fault_addr,
    input  logic [3:0]        fault_bit,
    input  logic              fault_val
);
    logic [DATA_W-1:0] raw;

    ram16k #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk(clk), .value(value), .load(load), .address(address), .out(raw)
    );

    always_comb begin
        out = raw;
        if (fault_en && address == fault_addr)
            out[fault_bit] = fault_val;
    end
endmodule

module tb_ram16k_bist;
    import ram16k_bist_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_s = 1'b0;
    logic [15:0] seed_s = '0;
    logic        busy_s, done_s, pass_s, ram_load_s;
    logic [13:0] fail_addr_s, ram_address_s;
    logic [15:0] fail_data_s, ram_value_s, ram_out_s;
    logic        start_f = 1'b0;
    logic [15:0] seed_f = '0;
    logic        busy_f, done_f, pass_f, ram_load_f;
    logic [13:0] fail_addr_f, ram_address_f;
    logic [15:0] fail_data_f, ram_value_f, ram_out_f;
    logic        fault_en = 1'b0;
    logic [13:0] fault_addr = '0;
    logic [3:0]  fault_bit = '0;
    logic        fault_val = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram16k_bist #(.LAST_ADDR(15)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .seed(seed_s),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .fail_addr(fail_addr_s), .fail_data(fail_data_s),
        .ram_value(ram_value_s), .ram_load(ram_load_s),
        .ram_address(ram_address_s), .ram_out(ram_out_s)
    );

    ram16k_fault u_ram_s (
        .clk(clk), .value(ram_value_s), .load(ram_load_s),
        .address(ram_address_s), .out(ram_out_s),
        .fault_en(fault_en), .fault_addr(fault_addr),
        .fault_bit(fault_bit), .fault_val(fault_val)
    );

    ram16k_bist u_dut_f (
        .clk(clk), .reset(reset), .start(start_f), .seed(seed_f),
        .busy(busy_f), .done(done_f), .pass(pass_f),
        .fail_addr(fail_addr_f), .fail_data(fail_data_f),
        .ram_value(ram_value_f), .ram_load(ram_load_f),
        .ram_address(ram_address_f), .ram_out(ram_out_f)
    );

    ram16k u_ram_f (
        .clk(clk), .value(ram_value_f), .load(ram_load_f),
        .address(ram_address_f), .out(ram_out_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_small(input logic [15:0] s);
        seed_s  = s;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start_s = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy_s, done_s, pass_s, ram_load_s} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags_s: got %b expected 0000",
                     {busy_s, done_s, pass_s, ram_load_s});
        end
        checks++;
        if ({fail_addr_s, fail_data_s, ram_value_s, ram_address_s} !== '0) begin
            errors++;
            $display("FAIL reset_buses_s: got %h %h %h %h expected 0",
                     fail_addr_s, fail_data_s, ram_value_s, ram_address_s);
        end
        checks++;
        if ({busy_f, done_f, pass_f, ram_load_f, fail_addr_f, fail_data_f,
             ram_value_f, ram_address_f} !== '0) begin
            errors++;
            $display("FAIL reset_full: got nonzero outputs expected all 0");
        end
        checks++;
        if (u_dut_s.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", u_dut_s.state);
        end
        reset   = 1'b0;
        start_s = 1'b0;
        tick();
        checks++;
        if (busy_s !== 1'b0 || ram_load_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b load=%b expected 0 0",
                     busy_s, ram_load_s);
        end
    endtask

    task automatic test_clean_run();
        int n;
        fault_en = 1'b0;
        start_small(16'h0003);
        checks++;
        if (busy_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL clean_busy: got busy=%b done=%b expected 1 0",
                     busy_s, done_s);
        end
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (ram_load_s !== 1'b1 || ram_address_s !== 14'(a) ||
                ram_value_s !== (16'(a) ^ 16'h0003)) begin
                errors++;
                $display("FAIL clean_w0[%0d]: got load=%b addr=%0d val=%h expected 1 %0d %h",
                         a, ram_load_s, ram_address_s, ram_value_s, a,
                         16'(a) ^ 16'h0003);
            end
            tick();
        end
        checks++;
        if (ram_load_s !== 1'b0 || ram_value_s !== 16'h0 || ram_address_s !== 14'd0) begin
            errors++;
            $display("FAIL clean_r0_start: got load=%b val=%h addr=%0d expected 0 0000 0",
                     ram_load_s, ram_value_s, ram_address_s);
        end
        n = 16;
        while (!done_s && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL clean_latency: got %0d expected 64", n);
        end
        checks++;
        if (pass_s !== 1'b1 || busy_s !== 1'b0 || fail_addr_s !== '0 || fail_data_s !== '0) begin
            errors++;
            $display("FAIL clean_result: got pass=%b busy=%b fa=%0d fd=%h expected 1 0 0 0000",
                     pass_s, busy_s, fail_addr_s, fail_data_s);
        end
    endtask

    task automatic test_fault_phase0();
        int n;
        logic saw_w1;
        fault_en   = 1'b1;
        fault_addr = 14'd9;
        fault_bit  = 4'd2;
        fault_val  = 1'b1;
        start_small(16'h0000);
        checks++;
        if (done_s !== 1'b0 || pass_s !== 1'b0) begin
            errors++;
            $display("FAIL f0_clear: got done=%b pass=%b expected 0 0", done_s, pass_s);
        end
        n = 0;
        saw_w1 = 1'b0;
        while (!done_s && n < 200) begin
            if (ram_load_s && n >= 16)
                saw_w1 = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (n !== 26) begin
            errors++;
            $display("FAIL f0_latency: got %0d expected 26", n);
        end
        checks++;
        if (pass_s !== 1'b0 || fail_addr_s !== 14'd9 || fail_data_s !== 16'h000D) begin
            errors++;
            $display("FAIL f0_result: got pass=%b fa=%0d fd=%h expected 0 9 000d",
                     pass_s, fail_addr_s, fail_data_s);
        end
        checks++;
        if (saw_w1 !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL f0_no_w1: got saw_w1=%b busy=%b expected 0 0", saw_w1, busy_s);
        end
    endtask

    task automatic test_fault_phase2();
        int n;
        fault_en   = 1'b1;
        fault_addr = 14'd4;
        fault_bit  = 4'd15;
        fault_val  = 1'b0;
        start_small(16'h0000);
        n = 0;
        while (!done_s && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 53) begin
            errors++;
            $display("FAIL f2_latency: got %0d expected 53", n);
        end
        checks++;
        if (pass_s !== 1'b0 || fail_addr_s !== 14'd4 || fail_data_s !== 16'h7FFB) begin
            errors++;
            $display("FAIL f2_result: got pass=%b fa=%0d fd=%h expected 0 4 7ffb",
                     pass_s, fail_addr_s, fail_data_s);
        end
        fault_en = 1'b0;
    endtask

    task automatic test_abort_restart();
        int n;
        start_small(16'h0055);
        for (int i = 1; i < 40; i++) begin
            start_s = (i == 10 || i == 33);
            tick();
        end
        start_s = 1'b0;
        checks++;
        if (ram_load_s !== 1'b1 || ram_address_s !== 14'd7 || ram_value_s !== 16'hFFAD) begin
            errors++;
            $display("FAIL abort_w1_cnt7: got load=%b addr=%0d val=%h expected 1 7 ffad",
                     ram_load_s, ram_address_s, ram_value_s);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({ram_load_s, busy_s, done_s} !== 3'b000 || ram_value_s !== 16'h0) begin
            errors++;
            $display("FAIL abort_after: got load=%b busy=%b done=%b val=%h expected 0 0 0 0000",
                     ram_load_s, busy_s, done_s, ram_value_s);
        end
        start_small(16'hFFFF);
        n = 0;
        while (!done_s && n < 200) begin
            start_s = (n == 5 || n == 20 || n == 50);
            tick();
            n++;
        end
        start_s = 1'b0;
        checks++;
        if (n !== 64 || pass_s !== 1'b1) begin
            errors++;
            $display("FAIL restart_run: got n=%0d pass=%b expected 64 1", n, pass_s);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        seed_s  = 16'h0001;
        start_s = 1'b1;
        tick();
        checks++;
        if (busy_s !== 1'b1 || done_s !== 1'b0 || ram_load_s !== 1'b1 ||
            ram_value_s !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b done=%b load=%b val=%h expected 1 0 1 0001",
                     busy_s, done_s, ram_load_s, ram_value_s);
        end
        tick();
        checks++;
        if (ram_address_s !== 14'd1 || ram_value_s !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_ignore: got addr=%0d val=%h expected 1 0000",
                     ram_address_s, ram_value_s);
        end
        start_s = 1'b0;
        n = 1;
        while (!done_s && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 64 || pass_s !== 1'b1) begin
            errors++;
            $display("FAIL b2b_run: got n=%0d pass=%b expected 64 1", n, pass_s);
        end
    endtask

    task automatic test_full_size();
        int n;
        seed_f  = 16'hA5A5;
        start_f = 1'b1;
        tick();
        start_f = 1'b0;
        n = 0;
        while (!done_f && n < 70000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 65536 || pass_f !== 1'b1 || busy_f !== 1'b0) begin
            errors++;
            $display("FAIL full_run: got n=%0d pass=%b busy=%b expected 65536 1 0",
                     n, pass_f, busy_f);
        end
        checks++;
        if (u_ram_f.mem[4739] !== 16'h48D9) begin
            errors++;
            $display("FAIL full_mem4739: got %h expected 48d9", u_ram_f.mem[4739]);
        end
        checks++;
        if (u_ram_f.mem[10861] !== 16'h7037) begin
            errors++;
            $display("FAIL full_mem10861: got %h expected 7037", u_ram_f.mem[10861]);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_fault_phase0();
        test_fault_phase2();
        test_abort_restart();
        test_back_to_back();
        test_full_size();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
